icache_refill: RTL and testbench
================================

ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 Parameters (name, default, meaning); derived widths shall be localparams:
- NFU, 2, functional units; line holds NFU 32-bit words
- NCACHE_ENTRIES, 256, cache lines; CACHEINDEX = clog2(NCACHE_ENTRIES)
- PHYSICAL_ADDRESS_LENGTH, 56, physical address bits
- Derived: CACHELINESIZE = NFU*32; CACHELINEINDEX = clog2(NFU*4); TAGSIZE = PHYSICAL_ADDRESS_LENGTH-CACHEINDEX-CACHELINEINDEX; CACHELINESIZE_PRESENT = CACHELINESIZE+1+TAGSIZE
REQ-002 Ports (name, direction, width, meaning); one clock, synchronous active-high reset:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- miss_valid  in  1  cache miss request present
- miss_addr  in  PHYSICAL_ADDRESS_LENGTH  missing fetch address
- miss_ready  out  1  refill engine can accept a miss
- mem_req  out  1  memory word read request
- mem_addr  out  PHYSICAL_ADDRESS_LENGTH  word address of current beat
- mem_ack  in  1  beat complete; mem_rdata/mem_err valid this cycle
- mem_rdata  in  32  read word
- mem_err  in  1  bus error on this beat
- wr_en  out  1  cache array write strobe
- wr_index  out  CACHEINDEX  cache line index written
- wr_line  out  CACHELINESIZE_PRESENT  line written: {data, tag, valid}
- refill_done  out  1  one-cycle pulse, line written valid
- refill_err  out  1  one-cycle pulse, refill aborted by mem_err

Function
REQ-003 Line format: bit 0 valid; bits [1 +: TAGSIZE] tag; word i at bits [1+TAGSIZE+32*i +: 32].
REQ-004 Address split: index = miss_addr[CACHELINEINDEX +: CACHEINDEX]; tag = miss_addr[CACHELINEINDEX+CACHEINDEX +: TAGSIZE]; low CACHELINEINDEX bits ignored (line base = address with those bits zero).
REQ-005 States: IDLE, FETCH, WRITE.
REQ-006 IDLE: miss_ready=1; miss_valid&&miss_ready at an edge latches base, index, tag, clears beat counter, enters FETCH.
REQ-007 FETCH: miss_ready=0; mem_req=1; mem_addr = base + 4*beat.
REQ-008 FETCH, mem_ack=1 && mem_err=0: mem_rdata stored as word[beat]; beat increments; mem_addr updates next cycle; mem_req stays high between beats.
REQ-009 FETCH, ack on beat NFU-1 without error: next state WRITE.
REQ-010 FETCH, mem_ack=1 && mem_err=1: discard beat, go to WRITE with error flag set.
REQ-011 WRITE (exactly one cycle): mem_req=0; wr_en=1; wr_index = latched index; wr_line = {words, tag, 1} with refill_done=1, or on error {zero data, tag, 0} with refill_err=1; next state IDLE.
REQ-012 mem_ack outside FETCH shall be ignored; mem_rdata only sampled when mem_ack=1 in FETCH.
REQ-013 Minimum latency (ack every cycle): accept edge T, beats T+1..T+NFU, wr_en at cycle T+NFU+1, miss_ready high at T+NFU+2.
REQ-014 miss_valid held during FETCH/WRITE shall not be accepted until IDLE; one refill outstanding at most.
REQ-015 wr_en, refill_done, refill_err shall never be high in any cycle other than WRITE; refill_done and refill_err mutually exclusive.

Reset
REQ-016 rst sampled high: state IDLE; miss_ready=1 from next cycle; mem_req=0, wr_en=0, refill_done=0, refill_err=0, beat=0; mem_addr, wr_index, wr_line = 0.
REQ-017 rst during FETCH or WRITE: refill aborted, no cache write issued, in-flight mem_ack ignored.

Verification
REQ-018 NFU=2, PAL=56, miss_addr=0x123458, acks each cycle with 0x11111111 then 0x22222222 -> mem_addr 0x123458 then 0x12345C; wr_index=0x8B; wr_line={0x22222222,0x11111111,tag 0x246,1}; refill_done one pulse.
REQ-019 miss_addr=0x12345C (misaligned within line) -> identical beats from 0x123458, identical wr_line.
REQ-020 mem_ack withheld 3 cycles per beat -> mem_req and mem_addr stable while waiting; wr_en only after second ack.
REQ-021 mem_err on beat 1 -> wr_en with valid=0, tag 0x246, data 0; refill_err pulse; no refill_done.
REQ-022 rst asserted one cycle after first beat ack -> no wr_en ever; miss_ready=1 after reset; fresh miss completes normally.
REQ-023 miss_valid held continuously for two different addresses -> second accepted only the cycle after WRITE; two wr_en pulses, correct index each.

Source files
------------

// File: rtl/icache_refill.sv
// Instruction-cache line refill engine: accepts one miss, fetches NFU words
// beat by beat from memory, then writes the assembled line (or an invalid line on bus error).
module icache_refill #(
  parameter  int NFU                     = 2,
  parameter  int NCACHE_ENTRIES          = 256,
  parameter  int PHYSICAL_ADDRESS_LENGTH = 56,
  localparam int CACHEINDEX              = $clog2(NCACHE_ENTRIES),
  localparam int CACHELINESIZE           = NFU*32,
  localparam int CACHELINEINDEX          = $clog2(NFU*4),
  localparam int TAGSIZE                 = PHYSICAL_ADDRESS_LENGTH-CACHEINDEX-CACHELINEINDEX,
  localparam int CACHELINESIZE_PRESENT   = CACHELINESIZE+1+TAGSIZE
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_valid,
  input  logic [PHYSICAL_ADDRESS_LENGTH-1:0] miss_addr,
  output logic                               miss_ready,
  output logic                               mem_req,
  output logic [PHYSICAL_ADDRESS_LENGTH-1:0] mem_addr,
  input  logic                               mem_ack,
  input  logic [31:0]                        mem_rdata,
  input  logic                               mem_err,
  output logic                               wr_en,
  output logic [CACHEINDEX-1:0]              wr_index,
  output logic [CACHELINESIZE_PRESENT-1:0]   wr_line,
  output logic                               refill_done,
  output logic                               refill_err
);

  localparam int BW  = (NFU > 1) ? $clog2(NFU) : 1;
  localparam int PAL = PHYSICAL_ADDRESS_LENGTH;

  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

  state_t                   state, state_n;
  logic [PAL-1:0]           base;
  logic [CACHEINDEX-1:0]    index;
  logic [TAGSIZE-1:0]       tag;
  logic [BW-1:0]            beat;
  logic                     err;
  logic [NFU-1:0][31:0]     words;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (miss_valid) state_n = FETCH;
      FETCH:   if (mem_ack && (mem_err || beat == BW'(NFU-1))) state_n = WRITE;
      WRITE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: latch the miss, count beats, capture words. An errored beat is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      base  <= '0;
      index <= '0;
      tag   <= '0;
      beat  <= '0;
      err   <= 1'b0;
      words <= '0;
    end else begin
      case (state)
        IDLE: if (miss_valid) begin
          base  <= miss_addr & ~PAL'(NFU*4-1);
          index <= miss_addr[CACHELINEINDEX +: CACHEINDEX];
          tag   <= miss_addr[CACHELINEINDEX+CACHEINDEX +: TAGSIZE];
          beat  <= '0;
          err   <= 1'b0;
        end
        FETCH: if (mem_ack) begin
          if (mem_err) err <= 1'b1;
          else begin
            for (int i = 0; i < NFU; i++)
              if (beat == BW'(i)) words[i] <= mem_rdata;
            beat <= beat + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    miss_ready  = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    wr_en       = 1'b0;
    wr_index    = '0;
    wr_line     = '0;
    refill_done = 1'b0;
    refill_err  = 1'b0;
    case (state)
      IDLE:  miss_ready = 1'b1;
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = base + (PAL'(beat) << 2);
      end
      WRITE: begin
        wr_en       = 1'b1;
        wr_index    = index;
        wr_line     = err ? {{CACHELINESIZE{1'b0}}, tag, 1'b0} : {words, tag, 1'b1};
        refill_done = !err;
        refill_err  = err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icache_refill.sv
// Bench for icache_refill: transaction-level reference model compared every cycle,
// directed scenarios pinned to hand-computed values, then randomized traffic.
module tb_icache_refill;

  localparam int NFU = 2, NCE = 256, PAL = 56;
  localparam int CI = 8, TS = 45, CLP = 110;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           miss_valid = 1'b0;
  logic [PAL-1:0] miss_addr = '0;
  logic           miss_ready;
  logic           mem_req;
  logic [PAL-1:0] mem_addr;
  logic           mem_ack = 1'b0;
  logic [31:0]    mem_rdata = '0;
  logic           mem_err = 1'b0;
  logic           wr_en;
  logic [CI-1:0]  wr_index;
  logic [CLP-1:0] wr_line;
  logic           refill_done;
  logic           refill_err;

  icache_refill #(.NFU(NFU), .NCACHE_ENTRIES(NCE), .PHYSICAL_ADDRESS_LENGTH(PAL)) dut (
    .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_addr(miss_addr),
    .miss_ready(miss_ready), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .wr_en(wr_en), .wr_index(wr_index), .wr_line(wr_line),
    .refill_done(refill_done), .refill_err(refill_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: one outstanding refill, collected words kept in a queue.
  bit             m_busy, m_wr, m_err;
  logic [PAL-1:0] m_base;
  logic [CI-1:0]  m_index;
  logic [TS-1:0]  m_tag;
  logic [CLP-1:0] m_line;
  logic [31:0]    m_q[$];
  logic [63:0]    ma;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_wr = 0; m_q.delete();
    end else if (m_wr) begin
      m_wr = 0;
    end else if (m_busy) begin
      if (mem_ack) begin
        if (mem_err) begin
          m_line = '0; m_line[1 +: TS] = m_tag;
          m_err = 1; m_wr = 1; m_busy = 0;
        end else begin
          m_q.push_back(mem_rdata);
          if (m_q.size() == NFU) begin
            m_line = '0; m_line[0] = 1'b1; m_line[1 +: TS] = m_tag;
            for (int i = 0; i < NFU; i++) m_line[1+TS+32*i +: 32] = m_q[i];
            m_err = 0; m_wr = 1; m_busy = 0;
          end
        end
      end
    end else if (miss_valid) begin
      ma      = 64'(miss_addr);
      m_base  = PAL'(ma - ma % (NFU*4));
      m_index = CI'((ma / (NFU*4)) % NCE);
      m_tag   = TS'(ma / (NFU*4*NCE));
      m_busy  = 1; m_err = 0; m_q.delete();
    end
  end

  // Compare process plus capture of observed writes/beats for the literal checks.
  bit             chk_on = 0;
  int             n_wr = 0, n_done = 0, n_errp = 0;
  logic [PAL-1:0] cap_addr[$];
  logic [CI-1:0]  cap_idx[$];
  logic [CLP-1:0] cap_line[$];

  always @(negedge clk) begin
    if (chk_on) begin
      chk("miss_ready",  128'(miss_ready),  128'(!m_busy && !m_wr));
      chk("mem_req",     128'(mem_req),     128'(m_busy));
      chk("mem_addr",    128'(mem_addr),    128'(m_busy ? PAL'(m_base + PAL'(4*m_q.size())) : PAL'(0)));
      chk("wr_en",       128'(wr_en),       128'(m_wr));
      chk("wr_index",    128'(wr_index),    128'(m_wr ? m_index : CI'(0)));
      chk("wr_line",     128'(wr_line),     128'(m_wr ? m_line : CLP'(0)));
      chk("refill_done", 128'(refill_done), 128'(m_wr && !m_err));
      chk("refill_err",  128'(refill_err),  128'(m_wr && m_err));
      if (wr_en) begin
        n_wr++; cap_idx.push_back(wr_index); cap_line.push_back(wr_line);
      end
      if (refill_done) n_done++;
      if (refill_err)  n_errp++;
      if (mem_req && mem_ack) cap_addr.push_back(mem_addr);
    end
  end

  // Memory responder: fixed delay and table data when directed, random otherwise.
  bit          rnd_mode = 0;
  int          ack_delay = 0, err_beat = -1, wait_cnt = 0, resp_beat = 0;
  logic [31:0] dtab[4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  always @(posedge clk) begin
    #2;
    if (mem_req) begin
      if (rnd_mode ? ($urandom_range(0, 2) == 0) : (wait_cnt >= ack_delay)) begin
        mem_ack   = 1'b1;
        mem_rdata = rnd_mode ? $urandom : dtab[resp_beat % 4];
        mem_err   = rnd_mode ? ($urandom_range(0, 11) == 0) : (resp_beat == err_beat);
        wait_cnt  = 0;
        resp_beat++;
      end else begin
        mem_ack = 1'b0; mem_rdata = $urandom; mem_err = 1'($urandom_range(0, 1));
        wait_cnt++;
      end
    end else begin
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom; mem_err = 1'($urandom_range(0, 1));
      wait_cnt = 0; resp_beat = 0;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!miss_ready && k < 100) begin step(); k++; end
    n_chk++;
    if (k >= 100) begin n_fail++; $display("FAIL idle_timeout: waited %0d cycles, limit 100", k); end
  endtask

  task automatic wait_wr(input int target);
    int k = 0;
    while (n_wr < target && k < 200) begin step(); k++; end
    n_chk++;
    if (k >= 200) begin n_fail++; $display("FAIL write_timeout: writes %0d expected %0d", n_wr, target); end
    step();
  endtask

  int d0, e0;

  task automatic run_miss(input logic [PAL-1:0] a, input int dly, input int eb);
    int w0;
    wait_idle();
    ack_delay = dly; err_beat = eb;
    cap_addr.delete(); cap_idx.delete(); cap_line.delete();
    w0 = n_wr; d0 = n_done; e0 = n_errp;
    miss_valid = 1'b1; miss_addr = a;
    step();
    miss_valid = 1'b0; miss_addr = PAL'({$urandom, $urandom});
    wait_wr(w0 + 1);
  endtask

  task automatic chk_line(input string p, input logic [CLP-1:0] exp_line, input int exp_done, input int exp_err);
    chk({p, "_nwr"}, 128'(cap_line.size()), 128'(1));
    if (cap_line.size() == 1) begin
      chk({p, "_line"}, 128'(cap_line[0]), 128'(exp_line));
      chk({p, "_idx"},  128'(cap_idx[0]),  128'(8'h8B));
    end
    chk({p, "_done"}, 128'(n_done - d0), 128'(exp_done));
    chk({p, "_err"},  128'(n_errp - e0), 128'(exp_err));
  endtask

  task automatic chk_beats(input string p);
    chk({p, "_nbeats"}, 128'(cap_addr.size()), 128'(2));
    if (cap_addr.size() == 2) begin
      chk({p, "_addr0"}, 128'(cap_addr[0]), 128'(56'h123458));
      chk({p, "_addr1"}, 128'(cap_addr[1]), 128'(56'h12345C));
    end
  endtask

  localparam logic [CLP-1:0] LGOOD = {32'h22222222, 32'h11111111, 45'h246, 1'b1};
  localparam logic [CLP-1:0] LBAD  = {64'h0, 45'h246, 1'b0};

  initial begin
    int w0;
    repeat (2) @(posedge clk);
    chk_on = 1;
    @(negedge clk);
    chk("rst_ready",  128'(miss_ready), 128'(1));
    chk("rst_memreq", 128'(mem_req),    128'(0));
    chk("rst_wr_en",  128'(wr_en),      128'(0));
    chk("rst_line",   128'(wr_line),    128'(0));
    step();
    rst = 1'b0;

    run_miss(56'h123458, 0, -1);
    chk_beats("aligned"); chk_line("aligned", LGOOD, 1, 0);
    run_miss(56'h12345C, 0, -1);
    chk_beats("misaligned"); chk_line("misaligned", LGOOD, 1, 0);
    run_miss(56'h123458, 3, -1);
    chk_beats("slowack"); chk_line("slowack", LGOOD, 1, 0);
    run_miss(56'h123458, 0, 1);
    chk_line("buserr", LBAD, 0, 1);

    // Reset one cycle after the first beat is acknowledged.
    wait_idle();
    ack_delay = 0; err_beat = -1; w0 = n_wr;
    miss_valid = 1'b1; miss_addr = 56'h123458;
    step();
    miss_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("rstmid_nowrite", 128'(n_wr - w0), 128'(0));
    chk("rstmid_ready",   128'(miss_ready), 128'(1));
    run_miss(56'h123458, 0, -1);
    chk_beats("afterrst"); chk_line("afterrst", LGOOD, 1, 0);

    // miss_valid held across two back-to-back refills.
    wait_idle();
    ack_delay = 1; err_beat = -1; w0 = n_wr; d0 = n_done;
    cap_idx.delete();
    miss_valid = 1'b1; miss_addr = 56'h123458;
    step();
    miss_addr = 56'h000040;
    wait_wr(w0 + 2);
    miss_valid = 1'b0;
    chk("held_nwr", 128'(cap_idx.size()), 128'(2));
    if (cap_idx.size() == 2) begin
      chk("held_idx0", 128'(cap_idx[0]), 128'(8'h8B));
      chk("held_idx1", 128'(cap_idx[1]), 128'(8'h08));
    end
    chk("held_done", 128'(n_done - d0), 128'(2));

    rnd_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      step();
      miss_valid = 1'($urandom_range(0, 1));
      miss_addr  = PAL'({$urandom, $urandom});
      rst        = ($urandom_range(0, 99) == 0);
    end
    step();
    rst = 1'b0; miss_valid = 1'b0; rnd_mode = 0;
    wait_idle();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
